// File: rtl/scrambler_pkg.sv
// rtl/scrambler_pkg.sv - shared constants, state encoding and 8-step keystream function
// Purpose: LFSR geometry for the 1 + x^14 + x^15 additive scrambler, the
// controller state enum, and lfsr_step8() which advances the LFSR eight bits
// (MSB first) while XORing a byte. No ports.
package scrambler_pkg;

  localparam int LFSR_W = 15;
  localparam int TAP_A  = 14;
  localparam int TAP_B  = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Returns {new_lfsr, scrambled_byte}; data_in[7] is scrambled first.
  function automatic logic [LFSR_W+7:0] lfsr_step8(input logic [LFSR_W-1:0] lfsr,
                                                   input logic [7:0]        data_in);
    logic [LFSR_W-1:0] l;
    logic [7:0]        o;
    logic              fb;
    l  = lfsr;
    o  = '0;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb   = l[TAP_A] ^ l[TAP_B];
      o[i] = data_in[i] ^ fb;
      l    = {l[LFSR_W-2:0], fb};
    end
    return {l, o};
  endfunction

endpackage

// File: rtl/scrambler_lfsr8.sv
// rtl/scrambler_lfsr8.sv - combinational 8-step keystream generator and byte XOR
// Purpose: purely combinational; the controller owns the LFSR register.
// Ports:
//   lfsr_i  current LFSR value
//   data_i  plaintext byte
//   lfsr_o  LFSR value after eight steps
//   data_o  scrambled byte
module scrambler_lfsr8
  import scrambler_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr_i,
  input  logic [7:0]        data_i,
  output logic [LFSR_W-1:0] lfsr_o,
  output logic [7:0]        data_o
);

  assign {lfsr_o, data_o} = lfsr_step8(lfsr_i, data_i);

endmodule

// File: rtl/scrambler_ctrl.sv
// rtl/scrambler_ctrl.sv - frame sequencer for the 15-bit additive scrambler
// Purpose: loads the LFSR on a start command, scrambles frame_len bytes through
// a single-stage valid/ready output register, flags the last byte and pulses
// done after the final output handshake.
// Optional feature macro: SCRAMBLER_CTRL_RESEED_EN (periodic reload of the
// start seed every RESEED_PERIOD accepted bytes).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, frame_len, seed   frame command (sampled only in IDLE)
//   s_valid, s_data, s_ready plaintext input stream
//   m_valid, m_data, m_last, m_ready  scrambled output stream
//   busy                     high in RUN and DRAIN
//   done                     one-cycle pulse at frame end
module scrambler_ctrl
  import scrambler_pkg::*;
#(
  parameter int                LEN_W         = 16,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED  = 15'h00A9,
  parameter int                RESEED_PERIOD = 188
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [LFSR_W-1:0] seed,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              m_valid_q, m_valid_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              done_q, done_d;

  logic [LFSR_W-1:0] lfsr_next;
  logic [7:0]        data_scr;
  logic              accept;
  logic              last_byte;

`ifdef SCRAMBLER_CTRL_RESEED_EN
  localparam int RC_W = (RESEED_PERIOD > 1) ? $clog2(RESEED_PERIOD) : 1;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic              reseed_hit;
  assign reseed_hit = (rc_q == RC_W'(RESEED_PERIOD - 1));
`else
  logic unused_reseed_period;
  assign unused_reseed_period = ^RESEED_PERIOD;
`endif

  scrambler_lfsr8 u_lfsr8 (
    .lfsr_i (lfsr_q),
    .data_i (s_data),
    .lfsr_o (lfsr_next),
    .data_o (data_scr)
  );

  // Input may advance when the output stage is empty or being drained this cycle.
  assign s_ready   = (state_q == ST_RUN) && (!m_valid_q || m_ready);
  assign accept    = s_valid && s_ready;
  assign last_byte = (rem_q == LEN_W'(1));

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    rem_d     = rem_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    done_d    = 1'b0;
`ifdef SCRAMBLER_CTRL_RESEED_EN
    seed_d    = seed_q;
    rc_d      = rc_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            lfsr_d  = seed;
            rem_d   = frame_len;
            state_d = ST_RUN;
`ifdef SCRAMBLER_CTRL_RESEED_EN
            seed_d  = seed;
            rc_d    = '0;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          m_data_d  = data_scr;
          m_valid_d = 1'b1;
          m_last_d  = last_byte;
          lfsr_d    = lfsr_next;
          rem_d     = rem_q - LEN_W'(1);
`ifdef SCRAMBLER_CTRL_RESEED_EN
          // The triggering byte already used the old LFSR; the next one starts from the seed.
          if (reseed_hit) begin
            lfsr_d = seed_q;
            rc_d   = '0;
          end else begin
            rc_d   = rc_q + RC_W'(1);
          end
`endif
          if (last_byte) state_d = ST_DRAIN;
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= DEFAULT_SEED;
      rem_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef SCRAMBLER_CTRL_RESEED_EN
      seed_q    <= DEFAULT_SEED;
      rc_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      rem_q     <= rem_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
`ifdef SCRAMBLER_CTRL_RESEED_EN
      seed_q    <= seed_d;
      rc_q      <= rc_d;
`endif
    end
  end

endmodule
